wb_arbiter2: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the boot ROM (or any single classic-cycle Wishbone slave) between the CPU instruction bus and data bus. Grants are round-robin and held for a whole bus cycle (`cyc`). A per-access timeout counter ends stalled accesses with an error so that a missing slave cannot hang the core.

---
 rtl/wb_arbiter2.sv | 132 +++++++++++++
 tb/tb_wb_arbiter2.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin grants held per cyc
// and a per-access timeout that terminates stalled strobes with an error.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i
);

  // A zero TIMEOUT still needs a legal one-bit counter; it simply never leaves zero.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0, gnt1, tmo;

  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Tie goes to whoever was not served last.
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0:    if (!m0_cyc_i) state_d = IDLE;
      GNT1:    if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (gnt0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (gnt1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
  end

  // An ack arriving in the expiry cycle wins over the error.
  assign tmo = TMO_EN && (gnt0 || gnt1) && (cnt_q == TMO_CNT) && !s_ack_i;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!TMO_EN || state_d == IDLE || tmo || !s_stb_o || s_ack_i) cnt_d = '0;
  end

  assign m0_ack_o = s_ack_i & gnt0;
  assign m1_ack_o = s_ack_i & gnt1;
  assign m0_err_o = tmo & gnt0;
  assign m1_err_o = tmo & gnt1;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a registered-ack ROM slave model and TIMEOUT=4.
module tb_wb_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [DW-1:0] m0_wdat = '0, m1_wdat = '0;
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic m0_we = 1'b0, m1_we = 1'b0;
  logic [DW/8-1:0] m0_sel = '0, m1_sel = '0;
  logic m0_cyc = 1'b0, m1_cyc = 1'b0, m0_stb = 1'b0, m1_stb = 1'b0;
  logic m0_ack, m1_ack, m0_err, m1_err;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic s_we, s_cyc, s_stb, s_ack;
  logic [DW/8-1:0] s_sel;

  logic ack_en = 1'b1, ack_force = 1'b0, ack_q = 1'b0;
  logic [DW-1:0] rom_q = '0;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_reset_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_rdat), .s_ack_i(s_ack)
  );

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {16'hB007, a[7:0], ~a[7:0]};
  endfunction

  // Boot ROM: one wait state, registered data and ack.
  always @(posedge clk) begin
    ack_q <= s_cyc & s_stb & ~ack_q & ack_en;
    rom_q <= rom(s_adr);
  end
  assign s_rdat = rom_q;
  assign s_ack  = ack_q | ack_force;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_masters();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    m0_adr = '0; m1_adr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_masters();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m0_adr = 32'h44;
    step();
    step();
    vecs++;
    if ({s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
      errs++; $display("FAIL reset_outputs got %b want 000000", {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err});
    end
    vecs++;
    if (s_adr !== '0 || s_sel !== '0 || s_we !== 1'b0 || s_wdat !== '0) begin
      errs++; $display("FAIL reset_slave_bus adr=%h sel=%h we=%b dat=%h want all 0", s_adr, s_sel, s_we, s_wdat);
    end
    vecs++;
    if (m0_rdat !== s_rdat || m1_rdat !== s_rdat) begin
      errs++; $display("FAIL reset_rdata m0=%h m1=%h want %h", m0_rdat, m1_rdat, s_rdat);
    end
    clear_masters();
    rst = 1'b0;
    step();
    vecs++;
    if (s_cyc !== 1'b0) begin errs++; $display("FAIL reset_idle s_cyc=%b want 0", s_cyc); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_adr = 32'h10; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1;
    #1;
    vecs++;
    if (s_stb !== 1'b0) begin errs++; $display("FAIL single_stb_early got %b want 0", s_stb); end
    step();
    vecs++;
    if (s_stb !== 1'b1 || s_adr !== 32'h10 || s_sel !== 4'hF || m0_ack !== 1'b0) begin
      errs++; $display("FAIL single_grant stb=%b adr=%h sel=%h ack=%b want 1/10/f/0", s_stb, s_adr, s_sel, m0_ack);
    end
    step();
    vecs++;
    if (m0_ack !== 1'b1 || m0_rdat !== rom(32'h10) || m1_ack !== 1'b0) begin
      errs++; $display("FAIL single_ack ack0=%b dat=%h ack1=%b want 1/%h/0", m0_ack, m0_rdat, m1_ack, rom(32'h10));
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    vecs++;
    if (s_cyc !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errs++; $display("FAIL single_release cyc=%b ack0=%b ack1=%b want 0/0/0", s_cyc, m0_ack, m1_ack);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_adr = 32'h11; m1_adr = 32'h20;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    vecs++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h11) begin
      errs++; $display("FAIL tie_first cyc=%b adr=%h want 1/11", s_cyc, s_adr);
    end
    step();
    vecs++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errs++; $display("FAIL tie_ack0 ack0=%b ack1=%b want 1/0", m0_ack, m1_ack);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    vecs++;
    if (s_cyc !== 1'b0) begin errs++; $display("FAIL tie_gap s_cyc=%b want 0", s_cyc); end
    step();
    vecs++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h20) begin
      errs++; $display("FAIL tie_second cyc=%b adr=%h want 1/20", s_cyc, s_adr);
    end
    step();
    vecs++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdat !== rom(32'h20)) begin
      errs++; $display("FAIL tie_ack1 ack1=%b ack0=%b dat=%h want 1/0/%h", m1_ack, m0_ack, m1_rdat, rom(32'h20));
    end
    clear_masters();
    step();
  endtask

  task automatic test_back_to_back();
    logic owner, got;
    do_reset();
    m0_adr = 32'h30; m1_adr = 32'h40;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int g = 0; g < 4; g++) begin
      owner = g[0];
      for (int i = 0; i < 8 && !s_cyc; i++) step();
      vecs++;
      if (s_cyc !== 1'b1 || s_adr !== (owner ? 32'h40 : 32'h30)) begin
        errs++; $display("FAIL b2b_grant%0d cyc=%b adr=%h want 1/%h", g, s_cyc, s_adr, owner ? 32'h40 : 32'h30);
      end
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        step();
        got = owner ? m1_ack : m0_ack;
      end
      vecs++;
      if (got !== 1'b1 || (owner ? m0_ack : m1_ack) !== 1'b0) begin
        errs++; $display("FAIL b2b_ack%0d owner_ack=%b other_ack=%b want 1/0", g, got, owner ? m0_ack : m1_ack);
      end
      if (owner) begin m1_cyc = 0; m1_stb = 0; end else begin m0_cyc = 0; m0_stb = 0; end
      step();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    clear_masters();
    step();
  endtask

  task automatic test_hold();
    do_reset();
    m1_adr = 32'h50; m1_cyc = 1; m1_stb = 1;
    step();
    m0_adr = 32'h60; m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++;
      if (s_adr !== 32'h50 || s_cyc !== 1'b1 || m0_ack !== 1'b0) begin
        errs++; $display("FAIL hold_%0d adr=%h cyc=%b ack0=%b want 50/1/0", i, s_adr, s_cyc, m0_ack);
      end
    end
    m1_cyc = 0; m1_stb = 0;
    step();
    vecs++;
    if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
      errs++; $display("FAIL hold_gap cyc=%b ack0=%b want 0/0", s_cyc, m0_ack);
    end
    step();
    vecs++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h60) begin
      errs++; $display("FAIL hold_handover cyc=%b adr=%h want 1/60", s_cyc, s_adr);
    end
    clear_masters();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    ack_en = 1'b0;
    m0_adr = 32'h70; m0_cyc = 1; m0_stb = 1;
    step();
    vecs++;
    if (s_stb !== 1'b1) begin errs++; $display("FAIL tmo_stb got %b want 1", s_stb); end
    for (int n = 1; n <= 13; n++) begin
      step();
      vecs++;
      if (m0_err !== (n == 4 || n == 9) || m0_ack !== 1'b0 || m1_err !== 1'b0) begin
        errs++; $display("FAIL tmo_cycle%0d err0=%b ack0=%b err1=%b want %b/0/0", n, m0_err, m0_ack, m1_err, n == 4 || n == 9);
      end
    end
    step();
    ack_force = 1'b1;
    #1;
    vecs++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
      errs++; $display("FAIL tmo_ack_wins ack0=%b err0=%b want 1/0", m0_ack, m0_err);
    end
    ack_force = 1'b0;
    clear_masters();
    step();
    ack_en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_adr = 32'h80; m1_cyc = 1; m1_stb = 1;
    step();
    vecs++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h80) begin
      errs++; $display("FAIL areset_pre cyc=%b adr=%h want 1/80", s_cyc, s_adr);
    end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if ({s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
      errs++; $display("FAIL areset_now got %b want 000000", {s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err});
    end
    m0_adr = 32'h90; m0_cyc = 1; m0_stb = 1;
    step();
    step();
    rst = 1'b0;
    step();
    vecs++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h90) begin
      errs++; $display("FAIL areset_first cyc=%b adr=%h want 1/90", s_cyc, s_adr);
    end
    clear_masters();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
